// File: rtl/sc_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// sc_cfg_sequencer
//
// Owns the eight scanconverter runtime configuration words. Firmware fills a
// shadow set through a small register port, then asks for a commit. All eight
// words are copied to the active outputs in a single clock edge:
// - at the next output VSYNC leading edge,
// - on a force, or
// - when the commit has been pending for TIMEOUT_CYCLES cycles.
// This keeps the scanconverter from ever seeing a torn configuration
// mid-frame. When an apply changes any of the output timing words
// (hv_out_config..hv_out_config3), mute_o is raised for MUTE_FRAMES frames.
//
// Ports:
//   PCLK_OUT_i          output pixel clock (only clock)
//   reset_n             synchronous, active-low reset
//   reg_addr_i[2:0]     word select (0..7, order as the config outputs below)
//   reg_wdata_i[31:0]   write data
//   reg_we_i            write strobe, one word per cycle
//   reg_rdsel_i         readback source: 0 = shadow, 1 = active
//   reg_rdata_o[31:0]   registered readback (1-cycle latency)
//   commit_i            pulse: apply at the next VSYNC leading edge
//   force_i             pulse: apply on the next clock
//   vsync_i             scanconverter VSYNC, active-low
//   *_config*_o         active configuration words
//   busy_o              commit pending (FSM in PENDING); doubles as state view
//   wr_err_o            sticky: write attempted while pending
//   timeout_o           sticky: last apply came from the timeout
//   apply_o             pulse in the first cycle new active values are visible
//   mute_o              post-apply mute window
//
// Register-port protocol: reg_we_i, commit_i and force_i are one-cycle
// strobes with no back-pressure. A write is accepted only while IDLE and lands
// in the shadow on the next edge. A write in the same cycle as commit_i or
// force_i is included in the applied set. Writes while PENDING are dropped
// and flagged on wr_err_o. commit_i while PENDING is ignored. force_i always
// wins over a VSYNC edge, which wins over the timeout.
// -----------------------------------------------------------------------------
module sc_cfg_sequencer #(
    parameter int MUTE_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 4194304,
    parameter int TO_W           = 23
) (
    input  logic        PCLK_OUT_i,
    input  logic        reset_n,
    input  logic [2:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        reg_we_i,
    input  logic        reg_rdsel_i,
    output logic [31:0] reg_rdata_o,
    input  logic        commit_i,
    input  logic        force_i,
    input  logic        vsync_i,
    output logic [31:0] hv_out_config_o,
    output logic [31:0] hv_out_config2_o,
    output logic [31:0] hv_out_config3_o,
    output logic [31:0] xy_out_config_o,
    output logic [31:0] xy_out_config2_o,
    output logic [31:0] misc_config_o,
    output logic [31:0] sl_config_o,
    output logic [31:0] sl_config2_o,
    output logic        busy_o,
    output logic        wr_err_o,
    output logic        timeout_o,
    output logic        apply_o,
    output logic        mute_o
);

    // Mute counter only needs to hold MUTE_FRAMES; keep at least one bit.
    localparam int MC_W = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       shadow_q [8];
    logic [31:0]       shadow_d [8];
    logic [31:0]       active_q [8];
    logic [31:0]       active_d [8];
    logic [31:0]       shadow_fwd [8];
    logic [31:0]       rdata_q, rdata_d;
    logic              vsync_prev_q;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_q, timeout_d;
    logic              wr_err_q, wr_err_d;
    logic              apply_q, apply_d;
    logic [MC_W-1:0]   mute_cnt_q, mute_cnt_d;

    logic              vs_edge;
    logic              apply_fire;
    logic              edge_used;
    logic              timing_chg;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        vs_edge = vsync_prev_q & ~vsync_i;

        // Shadow as it will be after this cycle's write; an apply in the same
        // cycle must see the new word.
        shadow_fwd = shadow_q;
        if ((state_q == ST_IDLE) && reg_we_i) begin
            shadow_fwd[reg_addr_i] = reg_wdata_i;
        end

        timing_chg = (shadow_fwd[0] != active_q[0]) |
                     (shadow_fwd[1] != active_q[1]) |
                     (shadow_fwd[2] != active_q[2]);

        state_d    = state_q;
        shadow_d   = shadow_fwd;
        active_d   = active_q;
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
        wr_err_d   = wr_err_q;
        apply_fire = 1'b0;
        edge_used  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (force_i) begin
                    apply_fire = 1'b1;
                end else if (commit_i) begin
                    state_d   = ST_PENDING;
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
                    wr_err_d  = 1'b0;
                end
            end
            ST_PENDING: begin
                if (reg_we_i) begin
                    wr_err_d = 1'b1;
                end
                if (to_cnt_q != TO_LAST) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                if (force_i) begin
                    apply_fire = 1'b1;
                    state_d    = ST_IDLE;
                end else if (vs_edge) begin
                    apply_fire = 1'b1;
                    edge_used  = 1'b1;
                    state_d    = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    apply_fire = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (apply_fire) begin
            active_d = shadow_fwd;
        end
        apply_d = apply_fire;

        // Mute window: a timing-changing apply (re)loads the frame count. The
        // edge that triggered an apply opens the new frame rather than ending
        // one, so it does not count down.
        mute_cnt_d = mute_cnt_q;
        if (apply_fire && timing_chg && (MUTE_FRAMES > 0)) begin
            mute_cnt_d = MC_W'(MUTE_FRAMES);
        end else if (vs_edge && !edge_used && (mute_cnt_q != '0)) begin
            mute_cnt_d = mute_cnt_q - MC_W'(1);
        end

        rdata_d = reg_rdsel_i ? active_q[reg_addr_i] : shadow_q[reg_addr_i];
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK_OUT_i) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            rdata_q      <= '0;
            vsync_prev_q <= 1'b1;
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            wr_err_q     <= 1'b0;
            apply_q      <= 1'b0;
            mute_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            rdata_q      <= rdata_d;
            vsync_prev_q <= vsync_i;
            to_cnt_q     <= to_cnt_d;
            timeout_q    <= timeout_d;
            wr_err_q     <= wr_err_d;
            apply_q      <= apply_d;
            mute_cnt_q   <= mute_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign hv_out_config_o  = active_q[0];
    assign hv_out_config2_o = active_q[1];
    assign hv_out_config3_o = active_q[2];
    assign xy_out_config_o  = active_q[3];
    assign xy_out_config2_o = active_q[4];
    assign misc_config_o    = active_q[5];
    assign sl_config_o      = active_q[6];
    assign sl_config2_o     = active_q[7];

    assign reg_rdata_o = rdata_q;
    assign busy_o      = (state_q == ST_PENDING);
    assign wr_err_o    = wr_err_q;
    assign timeout_o   = timeout_q;
    assign apply_o     = apply_q;
    assign mute_o      = (mute_cnt_q != '0);

endmodule

// File: tb/tb_sc_cfg_sequencer.sv
module tb_sc_cfg_sequencer;

    localparam int MUTE_FRAMES    = 2;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int TO_W           = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        reg_we_i;
    logic        reg_rdsel_i;
    logic [31:0] reg_rdata_o;
    logic        commit_i;
    logic        force_i;
    logic        vsync_i;
    logic [31:0] hv_out_config_o, hv_out_config2_o, hv_out_config3_o;
    logic [31:0] xy_out_config_o, xy_out_config2_o, misc_config_o;
    logic [31:0] sl_config_o, sl_config2_o;
    logic        busy_o, wr_err_o, timeout_o, apply_o, mute_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  addr;
        logic        rdsel;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab [16];

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    sc_cfg_sequencer #(
        .MUTE_FRAMES   (MUTE_FRAMES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) dut (
        .PCLK_OUT_i      (clk),
        .reset_n         (reset_n),
        .reg_addr_i      (reg_addr_i),
        .reg_wdata_i     (reg_wdata_i),
        .reg_we_i        (reg_we_i),
        .reg_rdsel_i     (reg_rdsel_i),
        .reg_rdata_o     (reg_rdata_o),
        .commit_i        (commit_i),
        .force_i         (force_i),
        .vsync_i         (vsync_i),
        .hv_out_config_o (hv_out_config_o),
        .hv_out_config2_o(hv_out_config2_o),
        .hv_out_config3_o(hv_out_config3_o),
        .xy_out_config_o (xy_out_config_o),
        .xy_out_config2_o(xy_out_config2_o),
        .misc_config_o   (misc_config_o),
        .sl_config_o     (sl_config_o),
        .sl_config2_o    (sl_config2_o),
        .busy_o          (busy_o),
        .wr_err_o        (wr_err_o),
        .timeout_o       (timeout_o),
        .apply_o         (apply_o),
        .mute_o          (mute_o)
    );

    // ---------------------------------------------------------------- tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we_i    = 1'b1;
        reg_addr_i  = a;
        reg_wdata_i = d;
        tick();
        reg_we_i    = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " hv0"}, hv_out_config_o, 32'h0);
        check({tag, " hv1"}, hv_out_config2_o, 32'h0);
        check({tag, " hv2"}, hv_out_config3_o, 32'h0);
        check({tag, " xy0"}, xy_out_config_o, 32'h0);
        check({tag, " xy1"}, xy_out_config2_o, 32'h0);
        check({tag, " misc"}, misc_config_o, 32'h0);
        check({tag, " sl0"}, sl_config_o, 32'h0);
        check({tag, " sl1"}, sl_config2_o, 32'h0);
        check({tag, " rdata"}, reg_rdata_o, 32'h0);
        check({tag, " busy"}, {31'h0, busy_o}, 32'h0);
        check({tag, " wr_err"}, {31'h0, wr_err_o}, 32'h0);
        check({tag, " timeout"}, {31'h0, timeout_o}, 32'h0);
        check({tag, " apply"}, {31'h0, apply_o}, 32'h0);
        check({tag, " mute"}, {31'h0, mute_o}, 32'h0);
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        // Readback table: shadow holds written pattern, active still 0.
        for (int i = 0; i < 8; i++) begin
            rd_tab[i].addr      = 3'(i);
            rd_tab[i].rdsel     = 1'b0;
            rd_tab[i].exp       = 32'h11111111 * (i + 1);
            rd_tab[i + 8].addr  = 3'(i);
            rd_tab[i + 8].rdsel = 1'b1;
            rd_tab[i + 8].exp   = 32'h0;
        end

        reset_n     = 1'b0;
        reg_addr_i  = 3'd0;
        reg_wdata_i = 32'h0;
        reg_we_i    = 1'b0;
        reg_rdsel_i = 1'b0;
        commit_i    = 1'b0;
        force_i     = 1'b0;
        vsync_i     = 1'b1;
        tick();
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // --- shadow writes and table-driven readback
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 32'h11111111 * (i + 1));
        end
        for (int i = 0; i < 16; i++) begin
            reg_addr_i  = rd_tab[i].addr;
            reg_rdsel_i = rd_tab[i].rdsel;
            tick();
            check($sformatf("readback a%0d s%0d", rd_tab[i].addr, rd_tab[i].rdsel),
                  reg_rdata_o, rd_tab[i].exp);
        end
        // read latency: new address only visible after the next edge
        reg_addr_i  = 3'd2;
        reg_rdsel_i = 1'b0;
        tick();
        check("rd_lat before", reg_rdata_o, 32'h33333333);
        reg_addr_i = 3'd4;
        #1;
        check("rd_lat hold", reg_rdata_o, 32'h33333333);
        tick();
        check("rd_lat after", reg_rdata_o, 32'h55555555);

        // --- commit waits for VSYNC, no timing change so no mute
        do_reset();
        wr(3'd5, 32'h000000A5);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        check("vs busy start", {31'h0, busy_o}, 32'h1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("vs busy hold", {31'h0, busy_o}, 32'h1);
            check("vs misc hold", misc_config_o, 32'h0);
        end
        vsync_i = 1'b0;
        tick();
        check("vs misc", misc_config_o, 32'h000000A5);
        check("vs apply", {31'h0, apply_o}, 32'h1);
        check("vs busy end", {31'h0, busy_o}, 32'h0);
        check("vs mute", {31'h0, mute_o}, 32'h0);
        check("vs timeout", {31'h0, timeout_o}, 32'h0);
        tick();
        check("vs apply pulse", {31'h0, apply_o}, 32'h0);
        vsync_i = 1'b1;
        tick();

        // --- timing change mutes for MUTE_FRAMES frames
        reg_we_i = 1'b1; reg_addr_i = 3'd0; reg_wdata_i = 32'h0035A6B4; force_i = 1'b1;
        tick();
        reg_we_i = 1'b0; force_i = 1'b0;
        check("mute setup hv", hv_out_config_o, 32'h0035A6B4);
        check("mute setup on", {31'h0, mute_o}, 32'h1);
        for (int f = 0; f < 2; f++) begin
            vsync_i = 1'b0; tick();
            vsync_i = 1'b1; tick();
        end
        check("mute setup clear", {31'h0, mute_o}, 32'h0);
        wr(3'd0, 32'h005005A0);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        check("mute busy", {31'h0, busy_o}, 32'h1);
        vsync_i = 1'b0; tick();
        check("mute hv", hv_out_config_o, 32'h005005A0);
        check("mute apply", {31'h0, apply_o}, 32'h1);
        check("mute f1", {31'h0, mute_o}, 32'h1);
        vsync_i = 1'b1; tick();
        check("mute f1 hi", {31'h0, mute_o}, 32'h1);
        vsync_i = 1'b0; tick();
        check("mute f2", {31'h0, mute_o}, 32'h1);
        vsync_i = 1'b1; tick();
        check("mute f2 hi", {31'h0, mute_o}, 32'h1);
        vsync_i = 1'b0; tick();
        check("mute f3 off", {31'h0, mute_o}, 32'h0);
        vsync_i = 1'b1; tick();

        // --- timeout apply
        wr(3'd6, 32'h0000CAFE);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            check("to busy", {31'h0, busy_o}, 32'h1);
            tick();
        end
        check("to busy last", {31'h0, busy_o}, 32'h1);
        check("to sl hold", sl_config_o, 32'h0);
        tick();
        check("to sl", sl_config_o, 32'h0000CAFE);
        check("to flag", {31'h0, timeout_o}, 32'h1);
        check("to apply", {31'h0, apply_o}, 32'h1);
        check("to busy end", {31'h0, busy_o}, 32'h0);
        check("to mute", {31'h0, mute_o}, 32'h0);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        check("to clear", {31'h0, timeout_o}, 32'h0);
        check("to busy again", {31'h0, busy_o}, 32'h1);

        // --- write while pending is dropped, then force
        wr(3'd2, 32'h0000DEAD);
        check("wr_err set", {31'h0, wr_err_o}, 32'h1);
        reg_addr_i  = 3'd2;
        reg_rdsel_i = 1'b0;
        tick();
        check("wr_err shadow2", reg_rdata_o, 32'h0);
        force_i = 1'b1;
        tick();
        force_i = 1'b0;
        check("force busy", {31'h0, busy_o}, 32'h0);
        check("force apply", {31'h0, apply_o}, 32'h1);
        check("force hv2", hv_out_config3_o, 32'h0);
        check("force timeout", {31'h0, timeout_o}, 32'h0);

        // --- same-cycle write + force, then reset mid-PENDING
        reg_we_i = 1'b1; reg_addr_i = 3'd7; reg_wdata_i = 32'h00001234; force_i = 1'b1;
        tick();
        reg_we_i = 1'b0; force_i = 1'b0;
        check("fwd sl2", sl_config2_o, 32'h00001234);
        check("fwd apply", {31'h0, apply_o}, 32'h1);
        check("fwd misc", misc_config_o, 32'h000000A5);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        check("rst busy pre", {31'h0, busy_o}, 32'h1);
        check("rst wr_err clr", {31'h0, wr_err_o}, 32'h0);
        reset_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        reset_n = 1'b1;
        tick();
        check("post_reset busy", {31'h0, busy_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
